pwm_spi_host: RTL

SPI master that sits directly upstream of the 7-channel PWM driver's SPI port. It accepts (channel, level) write requests over a valid/ready handshake and serialises each request into one SPI write frame to the driver:
- byte 0: command = 1000_0ccc
- byte 1: level
- mode 0, MSB-first on MOSI

It generates SCLK slowly enough for the driver, which oversamples SCLK on its own clock. An optional third byte reads back the driver's echo.

---
 rtl/pwm_spi_pkg.sv | 35 +++
 rtl/pwm_spi_host_timer.sv | 28 ++
 rtl/pwm_spi_host.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pwm_spi_pkg.sv
// Shared types and constants for the PWM-driver SPI host.
// PWM_SPI_HOST_READBACK_EN widens the frame to three bytes for the echo read.
package pwm_spi_pkg;

  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_W        = 3;
  localparam int BYTE_W        = 8;

`ifdef PWM_SPI_HOST_READBACK_EN
  localparam int NBITS = 3 * BYTE_W;
`else
  localparam int NBITS = 2 * BYTE_W;
`endif

  localparam int BIT_CNT_W    = $clog2(NBITS + 1);
  // Setup half, two halves per bit, hold half.
  localparam int FRAME_HALVES = 2 * NBITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [BYTE_W-1:0] build_cmd(input logic [ADDR_W-1:0] chan);
    logic [BYTE_W-1:0] cmd;
    cmd                = '0;
    cmd[CMD_WRITE_BIT] = 1'b1;
    cmd[ADDR_W-1:0]    = chan;
    return cmd;
  endfunction

endpackage

// File: rtl/pwm_spi_host_timer.sv
// Loadable down-counter: ticks when it reaches zero while enabled.
// The owner reloads it on every tick to get a periodic strobe.
module spi_half_period_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/pwm_spi_host.sv
// SPI mode-0 write master for the 7-channel PWM driver.
// Define PWM_SPI_HOST_READBACK_EN to append an echo byte and check it.
module pwm_spi_host
  import pwm_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_chan,
  input  logic [BYTE_W-1:0] req_level,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_err,
  output logic              spi_sclk,
  output logic              spi_cs,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int TMR_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(TMR_MAX);
  localparam logic [CNT_W-1:0]     DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NBITS);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("pwm_spi_host: CLK_DIV must be at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("pwm_spi_host: GAP_CYCLES must be at least 1");
  end

  state_t               r_state;
  logic [NBITS-1:0]     r_shift;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_cs;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_load;
  logic [CNT_W-1:0]     w_load_val;
  logic [NBITS-1:0]     w_frame;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_load     = w_accept || w_tick;
  assign w_load_val = (r_state == HOLD) ? GAP_LOAD : DIV_LOAD;

`ifdef PWM_SPI_HOST_READBACK_EN
  assign w_frame = {build_cmd(req_chan), req_level, {BYTE_W{1'b0}}};
`else
  assign w_frame = {build_cmd(req_chan), req_level};
`endif

  spi_half_period_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_state != IDLE),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state   <= SETUP;
          r_cs      <= 1'b0;
          r_mosi    <= w_frame[NBITS-1];
          r_shift   <= {w_frame[NBITS-2:0], 1'b0};
          r_bit_cnt <= '0;
        end
        SETUP: if (w_tick) begin
          r_sclk  <= 1'b1;
          r_state <= SHIFT;
        end
        // MOSI advances only on the falling edge so it is stable at every rise.
        SHIFT: if (w_tick) begin
          if (r_sclk) begin
            r_sclk    <= 1'b0;
            r_mosi    <= r_shift[NBITS-1];
            r_shift   <= {r_shift[NBITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else if (r_bit_cnt == LAST_BIT) begin
            r_state <= HOLD;
          end else begin
            r_sclk <= 1'b1;
          end
        end
        HOLD: if (w_tick) begin
          r_cs    <= 1'b1;
          r_done  <= 1'b1;
          r_state <= GAP;
        end
        GAP: if (w_tick) begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PWM_SPI_HOST_READBACK_EN
  localparam logic [BIT_CNT_W-1:0] RB_FIRST = BIT_CNT_W'(2 * BYTE_W);

  logic [BYTE_W-1:0] r_rb_data;
  logic [BYTE_W-1:0] r_level;
  logic              r_rb_err;
  logic              w_rb_sample;

  // Rising SCLK of the third byte; the driver shifts its echo out LSB first.
  assign w_rb_sample = (r_state == SHIFT) && w_tick && !r_sclk &&
                       (r_bit_cnt >= RB_FIRST) && (r_bit_cnt != LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rb_data <= '0;
      r_level   <= '0;
      r_rb_err  <= 1'b0;
    end else if (w_accept) begin
      r_rb_data <= '0;
      r_level   <= req_level;
      r_rb_err  <= 1'b0;
    end else if (w_rb_sample) begin
      r_rb_data <= {spi_miso, r_rb_data[BYTE_W-1:1]};
    end else if ((r_state == HOLD) && w_tick) begin
      r_rb_err <= (r_rb_data != r_level);
    end
  end

  assign rb_data = r_rb_data;
  assign rb_err  = r_rb_err;
`else
  logic w_unused_miso;
  assign w_unused_miso = spi_miso;
  assign rb_data       = '0;
  assign rb_err        = 1'b0;
`endif

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign spi_cs    = r_cs;
  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_mosi;

endmodule
